// File: rtl/branch_predictor_pkg.sv
// Shared sizing, BTB entry layout and counter encodings for the IF-stage branch predictor.
// Table sizing lives here so the entry struct and the index/tag helpers always agree.
package branch_predictor_pkg;

    localparam int ENTRIES = 64;
    localparam int IDX_W   = $clog2(ENTRIES);
    localparam int TAG_W   = 30 - IDX_W;

    localparam logic [1:0] CNT_SNT = 2'b00;
    localparam logic [1:0] CNT_WNT = 2'b01;
    localparam logic [1:0] CNT_WT  = 2'b10;
    localparam logic [1:0] CNT_ST  = 2'b11;

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
        logic [31:0]      target;
        logic [1:0]       cnt;
        logic             jump;
    } btb_entry_t;

    // PC[1:0] never reaches the table: index starts at bit 2, tag ends at bit 31.
    function automatic logic [IDX_W-1:0] pc_idx(input logic [31:0] pc);
        return pc[IDX_W+1:2];
    endfunction

    function automatic logic [TAG_W-1:0] pc_tag(input logic [31:0] pc);
        return pc[31:IDX_W+2];
    endfunction

endpackage

// File: rtl/branch_predictor_bp_table.sv
// BTB storage: flop array with a registered lookup read port and a single write port.
// Lookup reads return pre-write contents, matching a 1-cycle BRAM in read-first mode.
module bp_table
    import branch_predictor_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] rd_idx,
    output btb_entry_t       rd_entry,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  btb_entry_t       wr_entry,
    output btb_entry_t       wr_cur
);

    logic [ENTRIES-1:0] valid_q;
    btb_entry_t         mem [ENTRIES];
    btb_entry_t         rd_raw;

    // Only the valid bits are reset; the other fields are ignored while invalid.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
        end else if (wr_en) begin
            valid_q[wr_idx] <= wr_entry.valid;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en && !rst) begin
            mem[wr_idx] <= wr_entry;
        end
    end

    always_comb begin
        rd_raw       = mem[rd_idx];
        rd_raw.valid = valid_q[rd_idx];
    end

    always_ff @(posedge clk) begin
        rd_entry <= rd_raw;
    end

    // Current contents at the write index, so the updater can do read-modify-write.
    always_comb begin
        wr_cur       = mem[wr_idx];
        wr_cur.valid = valid_q[wr_idx];
    end

endmodule

// File: rtl/branch_predictor.sv
// IF-stage branch predictor: direct-mapped BTB with 2-bit saturating counters,
// 1-cycle lookup latency, trained from EXE-stage branch resolution.
module branch_predictor
    import branch_predictor_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        IF_Req,
    input  logic [31:0] IF_PC,
    input  logic        IF_Flush,
    output logic        PRE_Valid,
    output logic        PRE_Hit,
    output logic        PRE_Taken,
    output logic [31:0] PRE_Target,
    input  logic        EXE_Update,
    input  logic [31:0] EXE_PC,
    input  logic        EXE_Taken,
    input  logic [31:0] EXE_Target,
    input  logic        EXE_IsJump
);

    logic             req_q;
    logic [TAG_W-1:0] tag_q;
    btb_entry_t       rd_entry;
    btb_entry_t       wr_cur;
    btb_entry_t       wr_entry;
    logic             wr_en;
    logic             exe_hit;
    logic             unused_pc_bits;

    assign unused_pc_bits = ^{IF_PC[1:0], EXE_PC[1:0]};

    function automatic logic [1:0] cnt_next(input logic [1:0] cnt, input logic taken);
        if (taken) begin
            return (cnt == CNT_ST) ? CNT_ST : cnt + 2'd1;
        end
        return (cnt == CNT_SNT) ? CNT_SNT : cnt - 2'd1;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            req_q <= 1'b0;
        end else begin
            req_q <= IF_Req;
        end
    end

    always_ff @(posedge clk) begin
        tag_q <= pc_tag(IF_PC);
    end

    bp_table u_table (
        .clk      (clk),
        .rst      (rst),
        .rd_idx   (pc_idx(IF_PC)),
        .rd_entry (rd_entry),
        .wr_en    (wr_en),
        .wr_idx   (pc_idx(EXE_PC)),
        .wr_entry (wr_entry),
        .wr_cur   (wr_cur)
    );

    // Flush arrives in the response cycle and only masks the response.
    always_comb begin
        PRE_Valid  = req_q & ~IF_Flush;
        PRE_Hit    = PRE_Valid & rd_entry.valid & (rd_entry.tag == tag_q);
        PRE_Taken  = PRE_Hit & (rd_entry.jump | rd_entry.cnt[1]);
        PRE_Target = PRE_Valid ? rd_entry.target : 32'h0;
    end

    // Not-taken misses never allocate, so they must not disturb an aliasing entry.
    always_comb begin
        exe_hit  = wr_cur.valid & (wr_cur.tag == pc_tag(EXE_PC));
        wr_en    = 1'b0;
        wr_entry = wr_cur;
        if (EXE_Update) begin
            if (exe_hit) begin
                wr_en        = 1'b1;
                wr_entry.cnt = cnt_next(wr_cur.cnt, EXE_Taken);
                if (EXE_Taken) begin
                    wr_entry.target = EXE_Target;
                    wr_entry.jump   = EXE_IsJump;
                end
            end else if (EXE_Taken) begin
                wr_en           = 1'b1;
                wr_entry.valid  = 1'b1;
                wr_entry.tag    = pc_tag(EXE_PC);
                wr_entry.target = EXE_Target;
                wr_entry.jump   = EXE_IsJump;
                wr_entry.cnt    = EXE_IsJump ? CNT_ST : CNT_WT;
            end
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: directed scenarios plus randomized traffic,
// compared every cycle against a plain-array behavioural model of the BTB.
module tb_branch_predictor;

    logic        clk = 1'b0;
    logic        rst;
    logic        IF_Req;
    logic [31:0] IF_PC;
    logic        IF_Flush;
    logic        PRE_Valid;
    logic        PRE_Hit;
    logic        PRE_Taken;
    logic [31:0] PRE_Target;
    logic        EXE_Update;
    logic [31:0] EXE_PC;
    logic        EXE_Taken;
    logic [31:0] EXE_Target;
    logic        EXE_IsJump;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    // Behavioural model: 64 entries, index = PC bits 7:2, tag = PC bits 31:8.
    bit          m_valid [64];
    int unsigned m_tag   [64];
    logic [31:0] m_tgt   [64];
    int          m_cnt   [64];
    bit          m_jump  [64];

    bit          exp_req    = 1'b0;
    bit          exp_hit    = 1'b0;
    bit          exp_taken  = 1'b0;
    logic [31:0] exp_target = 32'h0;

    always #5 clk = ~clk;

    branch_predictor dut (
        .clk        (clk),
        .rst        (rst),
        .IF_Req     (IF_Req),
        .IF_PC      (IF_PC),
        .IF_Flush   (IF_Flush),
        .PRE_Valid  (PRE_Valid),
        .PRE_Hit    (PRE_Hit),
        .PRE_Taken  (PRE_Taken),
        .PRE_Target (PRE_Target),
        .EXE_Update (EXE_Update),
        .EXE_PC     (EXE_PC),
        .EXE_Taken  (EXE_Taken),
        .EXE_Target (EXE_Target),
        .EXE_IsJump (EXE_IsJump)
    );

    function automatic int idx_of(input logic [31:0] pc);
        return int'((pc >> 2) % 64);
    endfunction

    function automatic int unsigned tag_of(input logic [31:0] pc);
        return pc >> 8;
    endfunction

    // Model: lookup sees state before this edge's update.
    initial begin
        forever begin
            @(posedge clk);
            if (rst) begin
                exp_req = 1'b0;
                for (int k = 0; k < 64; k++) m_valid[k] = 1'b0;
            end else begin
                int i;
                int j;
                i = idx_of(IF_PC);
                exp_req    = IF_Req;
                exp_hit    = m_valid[i] && (m_tag[i] == tag_of(IF_PC));
                exp_taken  = exp_hit && (m_jump[i] || m_cnt[i] >= 2);
                exp_target = m_tgt[i];
                if (EXE_Update) begin
                    j = idx_of(EXE_PC);
                    if (m_valid[j] && m_tag[j] == tag_of(EXE_PC)) begin
                        if (EXE_Taken) begin
                            m_cnt[j]  = (m_cnt[j] == 3) ? 3 : m_cnt[j] + 1;
                            m_tgt[j]  = EXE_Target;
                            m_jump[j] = EXE_IsJump;
                        end else begin
                            m_cnt[j] = (m_cnt[j] == 0) ? 0 : m_cnt[j] - 1;
                        end
                    end else if (EXE_Taken) begin
                        m_valid[j] = 1'b1;
                        m_tag[j]   = tag_of(EXE_PC);
                        m_tgt[j]   = EXE_Target;
                        m_jump[j]  = EXE_IsJump;
                        m_cnt[j]   = EXE_IsJump ? 3 : 2;
                    end
                end
            end
        end
    end

    task automatic cmp(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s t=%0t got=%h exp=%h", name, $time, got, exp);
        end
    endtask

    // Per-cycle compare against the model, after inputs of the cycle have settled.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (chk_en) begin
                bit ev;
                ev = exp_req && !IF_Flush;
                cmp("valid", 32'(PRE_Valid), 32'(ev));
                cmp("hit", 32'(PRE_Hit), 32'(ev && exp_hit));
                cmp("taken", 32'(PRE_Taken), 32'(ev && exp_taken));
                if (ev && exp_taken) cmp("target", PRE_Target, exp_target);
                if (!ev) cmp("target_zero", PRE_Target, 32'h0);
            end
        end
    end

    task automatic step(input logic req, input logic [31:0] pc, input logic flush,
                        input logic upd, input logic [31:0] epc, input logic et,
                        input logic [31:0] etg, input logic ej, input logic r);
        @(negedge clk);
        IF_Req     = req;
        IF_PC      = pc;
        IF_Flush   = flush;
        EXE_Update = upd;
        EXE_PC     = epc;
        EXE_Taken  = et;
        EXE_Target = etg;
        EXE_IsJump = ej;
        rst        = r;
    endtask

    task automatic idle();
        step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    endtask

    task automatic lookup(input logic [31:0] pc);
        step(1'b1, pc, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    endtask

    task automatic update(input logic [31:0] pc, input logic t, input logic [31:0] tg, input logic j);
        step(1'b0, 32'h0, 1'b0, 1'b1, pc, t, tg, j, 1'b0);
    endtask

    initial begin
        rst = 1'b1; IF_Req = 1'b0; IF_PC = 32'h0; IF_Flush = 1'b0;
        EXE_Update = 1'b0; EXE_PC = 32'h0; EXE_Taken = 1'b0; EXE_Target = 32'h0; EXE_IsJump = 1'b0;
        step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
        step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
        chk_en = 1'b1;
        idle();
        #2 cmp("reset_valid", 32'(PRE_Valid), 32'h0);
        cmp("reset_target", PRE_Target, 32'h0);

        lookup(32'h1000); idle();
        #2 cmp("s1_valid", 32'(PRE_Valid), 32'h1);
        cmp("s1_hit", 32'(PRE_Hit), 32'h0);
        cmp("s1_taken", 32'(PRE_Taken), 32'h0);

        update(32'h1000, 1'b1, 32'h2000, 1'b0);
        lookup(32'h1000); idle();
        #2 cmp("s2_hit", 32'(PRE_Hit), 32'h1);
        cmp("s2_taken", 32'(PRE_Taken), 32'h1);
        cmp("s2_target", PRE_Target, 32'h2000);
        cmp("s2_model_cnt", 32'(m_cnt[0]), 32'd2);

        update(32'h1000, 1'b0, 32'h0, 1'b0);
        lookup(32'h1000); idle();
        #2 cmp("s3_taken_wnt", 32'(PRE_Taken), 32'h0);
        cmp("s3_model_cnt1", 32'(m_cnt[0]), 32'd1);
        update(32'h1000, 1'b0, 32'h0, 1'b0);
        update(32'h1000, 1'b0, 32'h0, 1'b0);
        cmp("s3_model_cnt0", 32'(m_cnt[0]), 32'd0);
        update(32'h1000, 1'b1, 32'h2000, 1'b0);
        lookup(32'h1000); idle();
        #2 cmp("s3_sat_low", 32'(PRE_Taken), 32'h0);
        cmp("s3_hit", 32'(PRE_Hit), 32'h1);

        update(32'h1100, 1'b1, 32'h5000, 1'b0);
        lookup(32'h1000); idle();
        #2 cmp("s4_alias_hit", 32'(PRE_Hit), 32'h0);
        lookup(32'h1100); idle();
        #2 cmp("s4_new_hit", 32'(PRE_Hit), 32'h1);
        cmp("s4_new_target", PRE_Target, 32'h5000);

        step(1'b1, 32'h3000, 1'b0, 1'b1, 32'h3000, 1'b1, 32'h4000, 1'b1, 1'b0);
        lookup(32'h3000);
        #2 cmp("s5_rbw_hit", 32'(PRE_Hit), 32'h0);
        idle();
        #2 cmp("s5_next_hit", 32'(PRE_Hit), 32'h1);
        cmp("s5_next_taken", 32'(PRE_Taken), 32'h1);

        lookup(32'h3000);
        step(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
        #2 cmp("s6_flush_valid", 32'(PRE_Valid), 32'h0);
        cmp("s6_flush_hit", 32'(PRE_Hit), 32'h0);
        cmp("s6_flush_target", PRE_Target, 32'h0);

        step(1'b1, 32'h3000, 1'b0, 1'b1, 32'h3004, 1'b1, 32'h7000, 1'b0, 1'b1);
        lookup(32'h3000); idle();
        #2 cmp("s6_rst_hit", 32'(PRE_Hit), 32'h0);

        for (int n = 0; n < 3000; n++) begin
            logic [31:0] pc;
            logic [31:0] epc;
            logic        jmp;
            pc  = (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(0, 3));
            epc = (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(0, 3));
            jmp = ($urandom_range(0, 3) == 0);
            step($urandom_range(0, 3) != 0, pc, $urandom_range(0, 9) == 0,
                 $urandom_range(0, 1) == 1, epc, jmp || ($urandom_range(0, 9) < 6),
                 $urandom, jmp, $urandom_range(0, 299) == 0);
        end
        idle();
        idle();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
